// File: rtl/io_digit_ctrl_pkg.sv
// Shared definitions for the output digit sequencer: state encoding, sign tag, digit counts.
package io_digit_ctrl_pkg;

   localparam int unsigned OCT_DIGITS_DEFAULT = 10;
   localparam int unsigned DEC_DIGITS_DEFAULT = 7;

   // Device symbol carrying the sign; bit0 is filled with the sign of C.
   localparam logic [4:0] SIGN_TAG = 5'b1_0000;

   // One-hot, same style as the arithmetic control block.
   typedef enum logic [5:0] {
      StIdle  = 6'b000001,
      StSign  = 6'b000010,
      StReq   = 6'b000100,
      StShift = 6'b001000,
      StSend  = 6'b010000,
      StDone  = 6'b100000
   } state_e;

endpackage

// File: rtl/io_digit_ctrl_if.sv
// Bundle of the sequencer's operation-unit, arithmetic-control and output-device signals.
interface io_digit_ctrl_if;

   logic       start_from_op;
   logic       fmt_dec_from_op;
   logic       clear_from_pu;
   logic       output_sign_from_ac;
   logic       reg_c1_from_au;
   logic       do_left_shift_c_from_ac;
   logic       ac_answer_from_ac;
   logic       order_io_to_ac;
   logic       shift_3_bit_to_ac;
   logic       shift_4_bit_to_ac;
   logic [4:0] dev_data_to_dev;
   logic       dev_valid_to_dev;
   logic       dev_ready_from_dev;
   logic       busy_to_op;
   logic       io_answer_to_op;

   // Environment side: operation unit, arithmetic control and output device.
   modport master (
      output start_from_op, fmt_dec_from_op, clear_from_pu, output_sign_from_ac,
             reg_c1_from_au, do_left_shift_c_from_ac, ac_answer_from_ac, dev_ready_from_dev,
      input  order_io_to_ac, shift_3_bit_to_ac, shift_4_bit_to_ac, dev_data_to_dev,
             dev_valid_to_dev, busy_to_op, io_answer_to_op
   );

   // Sequencer side.
   modport slave (
      input  start_from_op, fmt_dec_from_op, clear_from_pu, output_sign_from_ac,
             reg_c1_from_au, do_left_shift_c_from_ac, ac_answer_from_ac, dev_ready_from_dev,
      output order_io_to_ac, shift_3_bit_to_ac, shift_4_bit_to_ac, dev_data_to_dev,
             dev_valid_to_dev, busy_to_op, io_answer_to_op
   );

endinterface

// File: rtl/io_digit_ctrl.sv
// Output digit sequencer: emits the sign of C, then its magnitude MSD first, one shift group
// requested from the arithmetic control per digit, each digit handed over valid/ready.
module io_digit_ctrl
   import io_digit_ctrl_pkg::*;
#(
   parameter int unsigned OCT_DIGITS = OCT_DIGITS_DEFAULT,
   parameter int unsigned DEC_DIGITS = DEC_DIGITS_DEFAULT
) (
   input logic            clk,
   input logic            reset,
   io_digit_ctrl_if.slave bus
);

   localparam int unsigned max_digits = (OCT_DIGITS > DEC_DIGITS) ? OCT_DIGITS : DEC_DIGITS;
   localparam int unsigned cnt_w      = $clog2(max_digits + 1);

   state_e           state_q, state_d;
   logic             fmt_q, fmt_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic [3:0]       digit_sr_q, digit_sr_d;
   logic [cnt_w-1:0] limit;
   logic             busy;

   assign limit = fmt_q ? cnt_w'(DEC_DIGITS) : cnt_w'(OCT_DIGITS);

   // State register; clear aborts to idle with nothing pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         fmt_q      <= 1'b0;
         cnt_q      <= '0;
         digit_sr_q <= '0;
      end else if (bus.clear_from_pu) begin
         state_q    <= StIdle;
         fmt_q      <= 1'b0;
         cnt_q      <= '0;
         digit_sr_q <= '0;
      end else begin
         state_q    <= state_d;
         fmt_q      <= fmt_d;
         cnt_q      <= cnt_d;
         digit_sr_q <= digit_sr_d;
      end
   end

   // Next-state and output decode; clear forces every output low in its own cycle.
   always_comb begin
      state_d              = state_q;
      fmt_d                = fmt_q;
      cnt_d                = cnt_q;
      digit_sr_d           = digit_sr_q;
      bus.order_io_to_ac   = 1'b0;
      bus.dev_data_to_dev  = 5'b0;
      bus.dev_valid_to_dev = 1'b0;
      bus.io_answer_to_op  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start_from_op) begin
               fmt_d      = bus.fmt_dec_from_op;
               cnt_d      = '0;
               digit_sr_d = '0;
               state_d    = StSign;
            end
         end
         StSign: begin
            bus.dev_data_to_dev  = SIGN_TAG | {4'b0, bus.output_sign_from_ac};
            bus.dev_valid_to_dev = 1'b1;
            if (bus.dev_ready_from_dev) state_d = StReq;
         end
         StReq: begin
            bus.order_io_to_ac = 1'b1;
            state_d            = StShift;
         end
         StShift: begin
            // A shift in the same cycle as the answer is still captured.
            if (bus.do_left_shift_c_from_ac) digit_sr_d = {digit_sr_q[2:0], bus.reg_c1_from_au};
            if (bus.ac_answer_from_ac) state_d = StSend;
         end
         StSend: begin
            bus.dev_data_to_dev  = {1'b0, fmt_q & digit_sr_q[3], digit_sr_q[2:0]};
            bus.dev_valid_to_dev = 1'b1;
            if (bus.dev_ready_from_dev) begin
               cnt_d      = cnt_q + cnt_w'(1);
               digit_sr_d = '0;
               state_d    = (cnt_q + cnt_w'(1) == limit) ? StDone : StReq;
            end
         end
         StDone: begin
            bus.io_answer_to_op = 1'b1;
            state_d             = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy                  = (state_q != StIdle);
      bus.busy_to_op        = busy;
      bus.shift_3_bit_to_ac = busy & ~fmt_q;
      bus.shift_4_bit_to_ac = busy & fmt_q;

      if (bus.clear_from_pu) begin
         bus.order_io_to_ac    = 1'b0;
         bus.dev_data_to_dev   = 5'b0;
         bus.dev_valid_to_dev  = 1'b0;
         bus.io_answer_to_op   = 1'b0;
         bus.busy_to_op        = 1'b0;
         bus.shift_3_bit_to_ac = 1'b0;
         bus.shift_4_bit_to_ac = 1'b0;
      end
   end

endmodule

// File: tb/tb_io_digit_ctrl.sv
// Bench for io_digit_ctrl: emulates the arithmetic control and output device, predicts the
// symbol stream from the value of C and checks handshake behaviour every cycle.
module tb_io_digit_ctrl;

   logic clk;
   logic reset;
   io_digit_ctrl_if bus ();

   io_digit_ctrl #(
      .OCT_DIGITS(10),
      .DEC_DIGITS(7)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [4:0] exp_q[$];
   bit         exp_busy = 0;
   bit         cur_fmt = 0;
   bit         prev_acc = 0, prev_last = 0, prev_valid = 0, prev_ready = 0, prev_ans = 0;
   logic [4:0] prev_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] outs();
      return {21'd0, bus.order_io_to_ac, bus.shift_3_bit_to_ac, bus.shift_4_bit_to_ac,
              bus.dev_data_to_dev, bus.dev_valid_to_dev, bus.busy_to_op, bus.io_answer_to_op};
   endfunction

   // Expected symbols: sign tag, then magnitude groups from the MSB down.
   task automatic load_model(input logic s, input logic [29:0] m, input logic f);
      exp_q.delete();
      exp_q.push_back({4'b1000, s});
      if (f) for (int i = 0; i < 7; i++) exp_q.push_back(5'((m >> (26 - 4 * i)) & 30'hF));
      else   for (int i = 0; i < 10; i++) exp_q.push_back(5'((m >> (27 - 3 * i)) & 30'h7));
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      bit acc, last;
      if (reset || bus.clear_from_pu) begin
         chk(reset ? "reset_outputs" : "clear_outputs", outs(), 32'd0);
         exp_q.delete();
         prev_acc = 0; prev_last = 0; prev_valid = 0; prev_ready = 0; prev_ans = 0;
      end else begin
         chk("busy", bus.busy_to_op, exp_busy);
         chk("shift3", bus.shift_3_bit_to_ac, exp_busy & ~cur_fmt);
         chk("shift4", bus.shift_4_bit_to_ac, exp_busy & cur_fmt);
         chk("order_io", bus.order_io_to_ac, prev_acc & ~prev_last);
         chk("io_answer", bus.io_answer_to_op, prev_acc & prev_last);
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", bus.dev_valid_to_dev, 1);
            chk("hold_data", bus.dev_data_to_dev, prev_data);
         end
         if (prev_ans) chk("digit_latency", bus.dev_valid_to_dev, 1);
         if (bus.dev_valid_to_dev) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("dev_data", bus.dev_data_to_dev, exp_q[0]);
         end
         acc  = bus.dev_valid_to_dev && bus.dev_ready_from_dev;
         last = 0;
         if (acc && exp_q.size() > 0) begin
            exp_q.delete(0);
            last = (exp_q.size() == 0);
         end
         prev_acc   = acc;
         prev_last  = last;
         prev_valid = bus.dev_valid_to_dev;
         prev_ready = bus.dev_ready_from_dev;
         prev_data  = bus.dev_data_to_dev;
         prev_ans   = bus.ac_answer_from_ac;
      end
   end

   // One operation: start, emulate the arithmetic control and device, optionally disturb it.
   // Entered and left just after a rising edge.
   task automatic run_op(input logic s, input logic [29:0] m, input logic f, input bit rnd,
                         input int bp, input int clr, input bit sis, input bit rmid,
                         input int pin);
      int          ndig, gbits, acc_cnt, orders, answers, cyc, gap, ac_left, bp_seen, tail;
      bit          ans_pend, stray_prev, start_acc, aborted, done, sis_done, v_now, r_now, a_now;
      logic [29:0] c_mag;
      ndig  = f ? 7 : 10;
      gbits = f ? 4 : 3;
      load_model(s, m, f);
      if (pin == 1) begin
         chk("model_oct_len", exp_q.size(), 11);
         chk("model_oct_sign", exp_q[0], 5'h11);
         chk("model_oct_d0", exp_q[1], 1);
         chk("model_oct_d3", exp_q[4], 4);
         chk("model_oct_d7", exp_q[8], 0);
         chk("model_oct_d9", exp_q[10], 2);
      end else if (pin == 2) begin
         chk("model_dec_len", exp_q.size(), 8);
         chk("model_dec_sign", exp_q[0], 5'h10);
         chk("model_dec_d0", exp_q[1], 9);
         chk("model_dec_d1", exp_q[2], 0);
         chk("model_dec_d2", exp_q[3], 3);
         chk("model_dec_d4", exp_q[5], 12);
      end
      c_mag = m;
      bus.output_sign_from_ac = s;
      bus.reg_c1_from_au      = c_mag[29];
      bus.fmt_dec_from_op     = f;
      bus.start_from_op       = 1'b1;
      bus.dev_ready_from_dev  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_acc = !exp_busy;
      cur_fmt   = f;
      acc_cnt = 0; orders = 0; answers = 0; cyc = 0; gap = 0; ac_left = 0; bp_seen = 0;
      tail = 0; ans_pend = 0; stray_prev = 0; aborted = 0; done = 0; sis_done = 0;
      while (!done) begin
         @(negedge clk);
         v_now = bus.dev_valid_to_dev;
         r_now = bus.dev_ready_from_dev;
         a_now = bus.io_answer_to_op;
         if (bus.order_io_to_ac) begin
            orders++;
            ac_left  = gbits;
            gap      = rnd ? $urandom_range(0, 2) : 0;
            ans_pend = 0;
         end
         if (a_now) answers++;
         if (bp >= 0 && v_now && !r_now && acc_cnt == bp + 1) bp_seen++;
         if (v_now && r_now) acc_cnt++;
         @(posedge clk);
         #2;
         cyc++;
         if (bus.start_from_op) begin
            bus.start_from_op = 1'b0;
            if (start_acc) exp_busy = 1;
            bus.fmt_dec_from_op = 1'($urandom_range(0, 1));
         end
         bus.clear_from_pu = 1'b0;
         reset = 1'b0;
         if (bus.do_left_shift_c_from_ac && !stray_prev) c_mag = c_mag << 1;
         bus.do_left_shift_c_from_ac = 1'b0;
         bus.ac_answer_from_ac       = 1'b0;
         stray_prev                  = 0;
         bus.dev_ready_from_dev = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (bp >= 0 && acc_cnt == bp + 1 && bp_seen < 5) bus.dev_ready_from_dev = 1'b0;
         if (cyc > 3000) begin
            chk("timeout", 1, 0);
            done = 1;
         end else if (tail > 0) begin
            tail--;
            if (tail == 0) done = 1;
         end else if (a_now) begin
            exp_busy = 0;
            done     = 1;
         end else if (clr >= 0 && acc_cnt == clr + 1 && ac_left > 0 && ac_left < gbits) begin
            bus.clear_from_pu = 1'b1;
            exp_busy = 0; aborted = 1; tail = 3; ac_left = 0; ans_pend = 0;
         end else if (rmid && v_now && !r_now && acc_cnt >= 3) begin
            bus.dev_ready_from_dev = 1'b0;
            #1 reset = 1'b1;
            #1 chk("async_reset", outs(), 32'd0);
            exp_busy = 0; aborted = 1; tail = 2; ac_left = 0; ans_pend = 0;
         end else begin
            if (sis && !sis_done && v_now && !r_now && acc_cnt >= 2) begin
               bus.start_from_op      = 1'b1;
               bus.fmt_dec_from_op    = ~f;
               bus.dev_ready_from_dev = 1'b0;
               start_acc = !exp_busy;
               sis_done  = 1;
            end
            if (gap > 0) gap--;
            else if (ac_left > 0) begin
               bus.do_left_shift_c_from_ac = 1'b1;
               ac_left--;
               if (ac_left == 0) begin
                  if (rnd && $urandom_range(0, 1) == 1) bus.ac_answer_from_ac = 1'b1;
                  else ans_pend = 1;
               end
            end else if (ans_pend) begin
               bus.ac_answer_from_ac = 1'b1;
               ans_pend = 0;
            end else if (rnd && $urandom_range(0, 7) == 0) begin
               bus.do_left_shift_c_from_ac = 1'b1;
               stray_prev = 1;
            end
         end
         bus.reg_c1_from_au = c_mag[29];
      end
      if (!aborted) begin
         chk("order_count", orders, ndig);
         chk("answer_count", answers, 1);
         chk("model_drained", exp_q.size(), 0);
      end else begin
         chk("no_answer_after_abort", answers, 0);
      end
   endtask

   initial begin
      logic [29:0] m;
      reset = 1'b1;
      bus.start_from_op = 1'b0; bus.fmt_dec_from_op = 1'b0; bus.clear_from_pu = 1'b0;
      bus.output_sign_from_ac = 1'b0; bus.reg_c1_from_au = 1'b0;
      bus.do_left_shift_c_from_ac = 1'b0; bus.ac_answer_from_ac = 1'b0;
      bus.dev_ready_from_dev = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #2;
      // Octal, zero-wait, ready tied high.
      run_op(1'b1, 30'o1234567012, 1'b0, 0, -1, -1, 0, 0, 1);
      // Decimal, digits 9,0,3,7,12,5,14.
      run_op(1'b0, {28'h9037C5E, 2'b01}, 1'b1, 0, -1, -1, 0, 0, 2);
      // Backpressure on digit 3.
      run_op(1'b1, 30'o7654321076, 1'b0, 1, 3, -1, 0, 0, 0);
      // Clear during the shift of digit 4, then a full run.
      run_op(1'b0, 30'o1111222233, 1'b0, 1, -1, 4, 0, 0, 0);
      run_op(1'b1, 30'o3210765432, 1'b0, 1, -1, -1, 0, 0, 0);
      // Start while sending a digit.
      run_op(1'b0, 30'h2AAA_5555, 1'b1, 1, -1, -1, 1, 0, 0);
      // Asynchronous reset in the middle of a send, then a full run.
      run_op(1'b1, 30'o5555555555, 1'b0, 1, -1, -1, 0, 1, 0);
      run_op(1'b1, 30'h3FFF_FFFF, 1'b1, 1, -1, -1, 0, 0, 0);
      run_op(1'b0, 30'h0, 1'b0, 1, -1, -1, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         m = 30'($urandom);
         run_op(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)), 1, -1, -1, 0, 0, 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
